// File: rtl/core_pixel_drain.sv
`default_nettype none
// ============================================================================
// Module   : core_pixel_drain
// Purpose  : Drains one rotated RGB tile from output memory as 32-bit DMA words.
// Revision : 1.0 - initial release
// ============================================================================
module core_pixel_drain #(
   parameter int TILE_BYTES = 192,
   parameter int ADDR_W     = 8
) (
   input  logic              I_HCLK,
   input  logic              I_HRESET,
   input  logic              I_START,
   input  logic [7:0]        I_BYTE_COUNT,
   output logic [ADDR_W-1:0] O_PIXEL_OUT_ADDR0,
   output logic [ADDR_W-1:0] O_PIXEL_OUT_ADDR1,
   output logic [ADDR_W-1:0] O_PIXEL_OUT_ADDR2,
   output logic [ADDR_W-1:0] O_PIXEL_OUT_ADDR3,
   output logic              O_MEM_RD_EN,
   input  logic [7:0]        I_MEM_DATA0,
   input  logic [7:0]        I_MEM_DATA1,
   input  logic [7:0]        I_MEM_DATA2,
   input  logic [7:0]        I_MEM_DATA3,
   output logic [31:0]       O_DATA,
   output logic [3:0]        O_BYTE_EN,
   output logic              O_VALID,
   input  logic              I_DMA_READY,
   output logic              O_LAST,
   output logic              O_BUSY,
   output logic              O_DONE
);

   localparam logic [7:0] c_tile_max = 8'(TILE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [5:0]        k_q, k_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q [4];
   logic [ADDR_W-1:0] addr_d [4];
   logic [31:0]       data_q, data_d;
   logic [3:0]        be_q, be_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [7:0]        w_clamp;
   logic              w_is_last;
   logic [3:0]        w_be;
   logic [5:0]        w_fetch_k;
   logic [7:0]        w_mem [4];
   logic [31:0]       w_lane_data;
   logic [ADDR_W-1:0] w_lane_addr [4];

   assign w_clamp   = (I_BYTE_COUNT > c_tile_max) ? c_tile_max : I_BYTE_COUNT;
   assign w_is_last = ({1'b0, k_q, 2'b00} + 9'd4) >= {1'b0, cnt_q};
   assign w_fetch_k = (state_q == S_IDLE) ? 6'd0 : 6'(k_q + 6'd1);

   // Final word holds C mod 4 bytes, or a full word when C is a multiple of 4.
   always_comb begin
      w_be = 4'hF;
      if (w_is_last) begin
         case (cnt_q[1:0])
            2'd1:    w_be = 4'b0001;
            2'd2:    w_be = 4'b0011;
            2'd3:    w_be = 4'b0111;
            default: w_be = 4'b1111;
         endcase
      end
   end

   assign w_mem[0] = I_MEM_DATA0;
   assign w_mem[1] = I_MEM_DATA1;
   assign w_mem[2] = I_MEM_DATA2;
   assign w_mem[3] = I_MEM_DATA3;

   for (genvar n = 0; n < 4; n++) begin : g_lane
      assign w_lane_data[8*n +: 8] = w_be[n] ? w_mem[n] : 8'h00;
      assign w_lane_addr[n]        = ADDR_W'({w_fetch_k, 2'b00}) + ADDR_W'(n);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      rd_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (I_START) begin
               cnt_d = w_clamp;
               k_d   = 6'd0;
               if (w_clamp == 8'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  busy_d  = 1'b1;
                  rd_en_d = 1'b1;
                  addr_d  = w_lane_addr;
               end
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            data_d  = w_lane_data;
            be_d    = w_be;
            last_d  = w_is_last;
         end
         S_HOLD: begin
            if (I_DMA_READY) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (last_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_FETCH;
                  k_d     = w_fetch_k;
                  rd_en_d = 1'b1;
                  addr_d  = w_lane_addr;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge I_HCLK) begin
      if (I_HRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         rd_en_q <= 1'b0;
         for (int n = 0; n < 4; n++) addr_q[n] <= '0;
         data_q  <= '0;
         be_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign O_PIXEL_OUT_ADDR0 = addr_q[0];
   assign O_PIXEL_OUT_ADDR1 = addr_q[1];
   assign O_PIXEL_OUT_ADDR2 = addr_q[2];
   assign O_PIXEL_OUT_ADDR3 = addr_q[3];
   assign O_MEM_RD_EN       = rd_en_q;
   assign O_DATA            = data_q;
   assign O_BYTE_EN         = be_q;
   assign O_VALID           = valid_q;
   assign O_LAST            = last_q;
   assign O_BUSY            = busy_q;
   assign O_DONE            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_core_pixel_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_pixel_drain
// Purpose  : Scoreboard bench for core_pixel_drain with a one-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_pixel_drain;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              I_HRESET, I_START, I_DMA_READY;
   logic [7:0]        I_BYTE_COUNT;
   logic [ADDR_W-1:0] O_PIXEL_OUT_ADDR0, O_PIXEL_OUT_ADDR1, O_PIXEL_OUT_ADDR2, O_PIXEL_OUT_ADDR3;
   logic              O_MEM_RD_EN;
   logic [7:0]        I_MEM_DATA0, I_MEM_DATA1, I_MEM_DATA2, I_MEM_DATA3;
   logic [31:0]       O_DATA;
   logic [3:0]        O_BYTE_EN;
   logic              O_VALID, O_LAST, O_BUSY, O_DONE;

   always #5 clk = ~clk;

   core_pixel_drain #(.TILE_BYTES(192), .ADDR_W(ADDR_W)) dut (
      .I_HCLK(clk), .I_HRESET(I_HRESET), .I_START(I_START), .I_BYTE_COUNT(I_BYTE_COUNT),
      .O_PIXEL_OUT_ADDR0(O_PIXEL_OUT_ADDR0), .O_PIXEL_OUT_ADDR1(O_PIXEL_OUT_ADDR1),
      .O_PIXEL_OUT_ADDR2(O_PIXEL_OUT_ADDR2), .O_PIXEL_OUT_ADDR3(O_PIXEL_OUT_ADDR3),
      .O_MEM_RD_EN(O_MEM_RD_EN),
      .I_MEM_DATA0(I_MEM_DATA0), .I_MEM_DATA1(I_MEM_DATA1),
      .I_MEM_DATA2(I_MEM_DATA2), .I_MEM_DATA3(I_MEM_DATA3),
      .O_DATA(O_DATA), .O_BYTE_EN(O_BYTE_EN), .O_VALID(O_VALID),
      .I_DMA_READY(I_DMA_READY), .O_LAST(O_LAST), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  be;
      logic        last;
   } exp_t;

   exp_t wq[$];
   int   aq[$];
   int   total = 0, bad = 0;
   int   cyc = 0, rd_cnt = 0, valid_cnt = 0, hs_cnt = 0, done_cnt = 0;
   int   first_fetch_t = -1, last_hs_t = -1, done_t = -1, start_t = -1;

   function automatic logic [7:0] pat(int i);
      return 8'(i * 37 + 5);
   endfunction

   // Memory answers one cycle after a read strobe; otherwise returns filler.
   always @(posedge clk) begin
      if (O_MEM_RD_EN) begin
         I_MEM_DATA0 <= pat(int'(O_PIXEL_OUT_ADDR0));
         I_MEM_DATA1 <= pat(int'(O_PIXEL_OUT_ADDR1));
         I_MEM_DATA2 <= pat(int'(O_PIXEL_OUT_ADDR2));
         I_MEM_DATA3 <= pat(int'(O_PIXEL_OUT_ADDR3));
      end else begin
         I_MEM_DATA0 <= 8'hEE;
         I_MEM_DATA1 <= 8'hEE;
         I_MEM_DATA2 <= 8'hEE;
         I_MEM_DATA3 <= 8'hEE;
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic fail(string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   task automatic push_tile(int c);
      int cc;
      cc = (c > 192) ? 192 : c;
      for (int k = 0; 4 * k < cc; k++) begin
         exp_t e;
         int   rem;
         rem    = cc - 4 * k;
         e.last = (rem <= 4);
         e.be   = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
         e.d    = '0;
         for (int n = 0; n < 4; n++)
            if (e.be[n]) e.d[8*n +: 8] = pat(4 * k + n);
         wq.push_back(e);
         aq.push_back(4 * k);
      end
   endtask

   // Monitor: pops the scoreboard on every read strobe and every handshake.
   logic        prev_hs = 0, prev_hs_last = 0, prev_start = 0, prev_valid = 0;
   logic [31:0] prev_d = 0;
   logic [3:0]  prev_be = 0;
   logic        prev_last = 0;
   int          mon_a;
   exp_t        mon_e;

   always @(negedge clk) begin
      cyc++;
      if (I_HRESET) begin
         prev_hs = 0; prev_hs_last = 0; prev_start = 0; prev_valid = 0;
      end else begin
         if (prev_hs && !prev_hs_last) check("fetch_after_handshake", 32'(O_MEM_RD_EN), 32'd1);
         if (O_MEM_RD_EN) begin
            rd_cnt++;
            if (first_fetch_t < 0) first_fetch_t = cyc;
            check("read_allowed", 32'(!O_VALID && (prev_hs || prev_start)), 32'd1);
            if (aq.size() == 0) fail("unexpected_read");
            else begin
               mon_a = aq.pop_front();
               check("addr0", 32'(O_PIXEL_OUT_ADDR0), 32'(mon_a));
               check("addr1", 32'(O_PIXEL_OUT_ADDR1), 32'(mon_a + 1));
               check("addr2", 32'(O_PIXEL_OUT_ADDR2), 32'(mon_a + 2));
               check("addr3", 32'(O_PIXEL_OUT_ADDR3), 32'(mon_a + 3));
            end
         end
         if (O_VALID) begin
            valid_cnt++;
            if (prev_valid && !prev_hs) begin
               check("hold_data", O_DATA, prev_d);
               check("hold_be", 32'(O_BYTE_EN), 32'(prev_be));
               check("hold_last", 32'(O_LAST), 32'(prev_last));
            end
            if (I_DMA_READY) begin
               hs_cnt++;
               last_hs_t = cyc;
               if (wq.size() == 0) fail("unexpected_word");
               else begin
                  mon_e = wq.pop_front();
                  check("word_data", O_DATA, mon_e.d);
                  check("word_be", 32'(O_BYTE_EN), 32'(mon_e.be));
                  check("word_last", 32'(O_LAST), 32'(mon_e.last));
               end
            end
         end
         if (O_DONE) begin
            done_cnt++;
            done_t = cyc;
         end
         prev_start = I_START && !O_BUSY && !O_DONE && !O_VALID;
         if (prev_start) start_t = cyc;
         prev_hs      = O_VALID && I_DMA_READY;
         prev_hs_last = O_LAST;
         prev_valid   = O_VALID;
         prev_d       = O_DATA;
         prev_be      = O_BYTE_EN;
         prev_last    = O_LAST;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(int c);
      I_BYTE_COUNT = 8'(c);
      I_START      = 1'b1;
      tick();
      I_START      = 1'b0;
   endtask

   task automatic wait_done(int d0, int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      if (done_cnt == d0) fail("done_timeout");
   endtask

   task automatic wait_hs(int target, int budget);
      int n;
      n = 0;
      while (hs_cnt < target && n < budget) begin
         tick();
         n++;
      end
      if (hs_cnt < target) fail("handshake_timeout");
   endtask

   task automatic wait_valid(int budget);
      int n;
      n = 0;
      while (!O_VALID && n < budget) begin
         tick();
         n++;
      end
      check("valid_reached", 32'(O_VALID), 32'd1);
   endtask

   task automatic check_idle_outputs(string tag);
      check({tag, "_valid"}, 32'(O_VALID), 32'd0);
      check({tag, "_last"}, 32'(O_LAST), 32'd0);
      check({tag, "_busy"}, 32'(O_BUSY), 32'd0);
      check({tag, "_done"}, 32'(O_DONE), 32'd0);
      check({tag, "_rden"}, 32'(O_MEM_RD_EN), 32'd0);
      check({tag, "_data"}, O_DATA, 32'd0);
      check({tag, "_be"}, 32'(O_BYTE_EN), 32'd0);
      check({tag, "_addr"}, {O_PIXEL_OUT_ADDR3, O_PIXEL_OUT_ADDR2, O_PIXEL_OUT_ADDR1, O_PIXEL_OUT_ADDR0}, 32'd0);
   endtask

   int d0, h0, r0, v0;

   initial begin
      I_HRESET = 1'b1; I_START = 1'b0; I_BYTE_COUNT = 8'd0; I_DMA_READY = 1'b1;
      repeat (3) tick();
      I_HRESET = 1'b0;
      check_idle_outputs("reset");

      // Full tile, ready held high
      d0 = done_cnt; h0 = hs_cnt; first_fetch_t = -1;
      push_tile(192);
      start(192);
      wait_done(d0, 600);
      check("t1_words", 32'(hs_cnt - h0), 32'd48);
      check("t1_span", 32'(last_hs_t - first_fetch_t + 1), 32'd144);
      check("t1_done_t", 32'(done_t), 32'(last_hs_t + 1));
      check("t1_queue_empty", 32'(wq.size()), 32'd0);
      tick();

      // Partial final word
      d0 = done_cnt; h0 = hs_cnt;
      push_tile(10);
      start(10);
      wait_done(d0, 100);
      check("t2_words", 32'(hs_cnt - h0), 32'd3);
      check("t2_queue_empty", 32'(wq.size()), 32'd0);
      tick();

      // Back-pressure on word 2
      d0 = done_cnt; h0 = hs_cnt;
      push_tile(16);
      start(16);
      wait_hs(h0 + 2, 50);
      I_DMA_READY = 1'b0;
      wait_valid(10);
      r0 = rd_cnt;
      repeat (5) tick();
      check("t3_valid_held", 32'(O_VALID), 32'd1);
      check("t3_no_read", 32'(rd_cnt), 32'(r0));
      I_DMA_READY = 1'b1;
      wait_done(d0, 100);
      check("t3_words", 32'(hs_cnt - h0), 32'd4);
      tick();

      // Zero-byte tile
      d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
      start(0);
      wait_done(d0, 10);
      check("t4_done_t", 32'(done_t), 32'(start_t + 1));
      repeat (3) tick();
      check("t4_no_read", 32'(rd_cnt), 32'(r0));
      check("t4_no_valid", 32'(valid_cnt), 32'(v0));

      // Reset while word 20 is held
      d0 = done_cnt; h0 = hs_cnt;
      push_tile(192);
      start(192);
      wait_hs(h0 + 20, 200);
      I_DMA_READY = 1'b0;
      wait_valid(10);
      I_HRESET = 1'b1;
      tick();
      I_HRESET = 1'b0;
      wq.delete();
      aq.delete();
      check_idle_outputs("midreset");
      repeat (5) tick();
      check("t5_no_done", 32'(done_cnt), 32'(d0));
      I_DMA_READY = 1'b1;
      h0 = hs_cnt;
      push_tile(8);
      start(8);
      wait_done(d0, 50);
      check("t5_restart_words", 32'(hs_cnt - h0), 32'd2);
      tick();

      // Clamped count plus an ignored second start
      d0 = done_cnt; h0 = hs_cnt; r0 = rd_cnt;
      push_tile(250);
      start(250);
      repeat (30) tick();
      I_BYTE_COUNT = 8'd16;
      I_START = 1'b1;
      tick();
      I_START = 1'b0;
      wait_done(d0, 600);
      repeat (10) tick();
      check("t6_one_done", 32'(done_cnt - d0), 32'd1);
      check("t6_words", 32'(hs_cnt - h0), 32'd48);
      check("t6_reads", 32'(rd_cnt - r0), 32'd48);
      check("t6_queue_empty", 32'(wq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
